// File: rtl/wb_commit_unit_pkg.sv
// Shared definitions for the writeback/commit stage: FSM encoding and
// load size/sign codes carried in funct3.
package wb_commit_unit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/wb_commit_unit_load_extend.sv
// Combinational load alignment and sign/zero extension of a raw 32-bit
// memory word. Unused funct3 codes pass the word through untouched.
module load_extend
  import wb_commit_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_low,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/half, then extend according to funct3.
  always_comb begin
    case (addr_low)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    // Halfword loads ignore addr_low[0]; misalignment is not trapped here.
    half_sel = addr_low[1] ? word[31:16] : word[15:0];

    data = word;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: accepts one retiring instruction, waits for the
// memory response on loads/stores, and issues one register-file write plus
// a commit strobe per instruction.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for the next instruction from execute
// WAIT_MEM | load/store captured, waiting for the memory response
// WRITE    | single retire cycle: commit strobe and register-file write
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic                  in_mem_op,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_low,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  mem_resp_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit
);

  wb_state_e state, state_next;

  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  rd_wen_q;
  logic [DATA_WIDTH-1:0] alu_q;
  logic                  mem_op_q;
  logic                  is_load_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_low_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic [DATA_WIDTH-1:0] load_data;

  load_extend u_load_extend (
    .word     (mem_data_q),
    .addr_low (addr_low_q),
    .funct3   (funct3_q),
    .data     (load_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture the instruction on acceptance and the memory word on response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= '0;
      rd_wen_q   <= 1'b0;
      alu_q      <= '0;
      mem_op_q   <= 1'b0;
      is_load_q  <= 1'b0;
      funct3_q   <= 3'd0;
      addr_low_q <= 2'd0;
      mem_data_q <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        rd_q       <= in_rd;
        rd_wen_q   <= in_rd_wen;
        alu_q      <= in_alu_result;
        mem_op_q   <= in_mem_op;
        is_load_q  <= in_is_load;
        funct3_q   <= in_funct3;
        addr_low_q <= in_addr_low;
      end
      if (state == WAIT_MEM && mem_resp_valid) begin
        mem_data_q <= mem_resp_data;
      end
    end
  end

  // Next-state and output decode. Reset suppresses the strobes so a reset
  // landing on the WRITE cycle never retires the discarded instruction.
  always_comb begin
    state_next     = state;
    in_ready       = 1'b0;
    mem_resp_ready = 1'b0;
    rf_wen         = 1'b0;
    rf_waddr       = '0;
    rf_wdata       = '0;
    commit         = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = in_mem_op ? WAIT_MEM : WRITE;
      end
      WAIT_MEM: begin
        mem_resp_ready = !rst;
        if (mem_resp_valid) state_next = WRITE;
      end
      WRITE: begin
        commit     = !rst;
        rf_wen     = !rst && rd_wen_q && (rd_q != '0);
        rf_waddr   = rd_q;
        rf_wdata   = (mem_op_q && is_load_q) ? load_data : alu_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: table of single-instruction
// vectors plus hand sequences for stray responses, reset and back-to-back.
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [31:0] in_alu_result;
  logic        in_mem_op;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_low;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit;

  wb_commit_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_alu_result(in_alu_result),
    .in_mem_op(in_mem_op), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_low(in_addr_low),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_ready(mem_resp_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit(commit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rd_wen;
    logic [31:0] alu;
    logic        mem_op;
    logic        is_load;
    logic [2:0]  f3;
    logic [1:0]  al;
    logic [31:0] word;
    int          waits;
    logic        exp_wen;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   n_cmp = 0;
  int   n_err = 0;
  int   commit_cnt = 0;
  int   push_cnt = 0;
  int   saved_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic wen, input logic [31:0] data);
    exp_t e;
    e.rd = rd; e.wen = wen; e.data = data;
    sb.push_back(e);
    push_cnt++;
  endtask

  // Scoreboard consumer: every commit pulse pops one expected write.
  always @(negedge clk) begin
    if (commit) begin
      commit_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_commit", {31'd0, commit}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rf_wen", {31'd0, rf_wen}, {31'd0, e.wen});
        if (e.wen) check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.rd});
        check("rf_wdata", rf_wdata, e.data);
      end
    end else if (rf_wen) begin
      check("rf_wen_outside_commit", {31'd0, rf_wen}, 32'd0);
    end
  end

  task automatic present(input vec_t v);
    in_valid      = 1'b1;
    in_rd         = v.rd;
    in_rd_wen     = v.rd_wen;
    in_alu_result = v.alu;
    in_mem_op     = v.mem_op;
    in_is_load    = v.is_load;
    in_funct3     = v.f3;
    in_addr_low   = v.al;
  endtask

  task automatic run_op(input vec_t v);
    present(v);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    push_exp(v.rd, v.exp_wen, v.exp_data);
    tick();
    in_valid = 1'b0;
    if (v.mem_op) begin
      check("mem_resp_ready_wait", {31'd0, mem_resp_ready}, 32'd1);
      check("in_ready_wait", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < v.waits; i++) begin
        check("no_early_commit", {31'd0, commit}, 32'd0);
        tick();
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = v.word;
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'hDEAD_0000;
    end
    check("commit_cycle", {31'd0, commit}, 32'd1);
    check("in_ready_in_write", {31'd0, in_ready}, 32'd0);
    tick();
    check("in_ready_after", {31'd0, in_ready}, 32'd1);
    check("commit_drop", {31'd0, commit}, 32'd0);
  endtask

  vec_t v;

  initial begin
    //           rd     wen   alu            mem   ld    f3    al    word           w  e_wen e_data
    vecs[0]  = '{5'd5,  1'b1, 32'h1234_5678, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0,         0, 1'b1, 32'h1234_5678};
    vecs[1]  = '{5'd3,  1'b1, 32'h0,         1'b1, 1'b1, 3'd0, 2'd3, 32'h80FF_0011, 4, 1'b1, 32'hFFFF_FF80};
    vecs[2]  = '{5'd4,  1'b1, 32'h0,         1'b1, 1'b1, 3'd4, 2'd3, 32'h80FF_0011, 4, 1'b1, 32'h0000_0080};
    vecs[3]  = '{5'd6,  1'b1, 32'h0,         1'b1, 1'b1, 3'd1, 2'd2, 32'h8001_7FFF, 1, 1'b1, 32'hFFFF_8001};
    vecs[4]  = '{5'd7,  1'b1, 32'h0,         1'b1, 1'b1, 3'd5, 2'd2, 32'h8001_7FFF, 2, 1'b1, 32'h0000_8001};
    vecs[5]  = '{5'd8,  1'b1, 32'h0,         1'b1, 1'b1, 3'd2, 2'd1, 32'h8001_7FFF, 0, 1'b1, 32'h8001_7FFF};
    vecs[6]  = '{5'd0,  1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0,         0, 1'b0, 32'hDEAD_BEEF};
    vecs[7]  = '{5'd9,  1'b1, 32'h0,         1'b1, 1'b1, 3'd0, 2'd1, 32'h0000_7F00, 1, 1'b1, 32'h0000_007F};
    vecs[8]  = '{5'd10, 1'b1, 32'h0,         1'b1, 1'b1, 3'd1, 2'd3, 32'h1234_5678, 1, 1'b1, 32'h0000_1234};
    vecs[9]  = '{5'd11, 1'b1, 32'h0,         1'b1, 1'b1, 3'd3, 2'd2, 32'hCAFE_F00D, 3, 1'b1, 32'hCAFE_F00D};
    vecs[10] = '{5'd12, 1'b0, 32'h0,         1'b1, 1'b1, 3'd4, 2'd0, 32'h0000_00A5, 1, 1'b0, 32'h0000_00A5};
    vecs[11] = '{5'd13, 1'b1, 32'h0000_0055, 1'b1, 1'b0, 3'd2, 2'd0, 32'h0000_FFFF, 2, 1'b1, 32'h0000_0055};

    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_rd_wen = 1'b0; in_alu_result = '0;
    in_mem_op = 1'b0; in_is_load = 1'b0; in_funct3 = '0; in_addr_low = '0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mem_resp_ready", {31'd0, mem_resp_ready}, 32'd0);
    check("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    check("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_commit", {31'd0, commit}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // Stray response in IDLE is ignored, then a store retires once.
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_2222;
    check("stray_resp_ready", {31'd0, mem_resp_ready}, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    check("stray_in_ready", {31'd0, in_ready}, 32'd1);
    check("stray_no_commit", {31'd0, commit}, 32'd0);
    v = '{5'd14, 1'b0, 32'h0000_0077, 1'b1, 1'b0, 3'd2, 2'd0, 32'h0, 1, 1'b0, 32'h0000_0077};
    run_op(v);

    // Reset in WAIT_MEM followed by a late response: nothing retires.
    saved_cnt = commit_cnt;
    v = '{5'd15, 1'b1, 32'h0, 1'b1, 1'b1, 3'd2, 2'd0, 32'h0, 0, 1'b1, 32'h0};
    present(v);
    tick();
    in_valid = 1'b0;
    check("rst_mid_wait", {31'd0, mem_resp_ready}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_BAD0;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_resp_ready", {31'd0, mem_resp_ready}, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    repeat (3) tick();
    check("post_rst_no_commit", commit_cnt, saved_cnt);

    // in_valid held high across three ALU ops: accepted every other cycle.
    saved_cnt = commit_cnt;
    v = '{5'd21, 1'b1, 32'hA000_0001, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 0, 1'b1, 32'hA000_0001};
    present(v); push_exp(v.rd, 1'b1, v.alu);
    check("b2b_ready0", {31'd0, in_ready}, 32'd1);
    tick();
    check("b2b_busy1", {31'd0, in_ready}, 32'd0);
    v = '{5'd22, 1'b1, 32'hA000_0002, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 0, 1'b1, 32'hA000_0002};
    present(v); push_exp(v.rd, 1'b1, v.alu);
    tick();
    check("b2b_ready2", {31'd0, in_ready}, 32'd1);
    tick();
    check("b2b_busy3", {31'd0, in_ready}, 32'd0);
    v = '{5'd23, 1'b1, 32'hA000_0003, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 0, 1'b1, 32'hA000_0003};
    present(v); push_exp(v.rd, 1'b1, v.alu);
    tick();
    check("b2b_ready4", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("b2b_commits", commit_cnt - saved_cnt, 32'd3);

    check("sb_empty", sb.size(), 32'd0);
    check("commit_total", commit_cnt, push_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Writeback/commit stage; the writer-side driver for the integer register file.
- Accepts one retiring instruction from the execute stage over a valid/ready handshake.
- For loads and stores, waits for the memory response; for loads, aligns and extends the returned data.
- Issues exactly one register-file write pulse plus a commit strobe per instruction; the strobe gates register-file writes.

Parameters:
ADDR_WIDTH, 5, register index width
DATA_WIDTH, 32, datapath width; the load-extension logic is defined for 32 only

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  execute stage presents an instruction
in_ready  out  1  unit can accept an instruction
in_rd  in  ADDR_WIDTH  destination register index
in_rd_wen  in  1  instruction writes rd
in_alu_result  in  DATA_WIDTH  result for non-load instructions
in_mem_op  in  1  instruction is a load or store; wait for memory response
in_is_load  in  1  memory op is a load; qualified by in_mem_op
in_funct3  in  3  load size/sign: 0=LB 1=LH 2=LW 4=LBU 5=LHU
in_addr_low  in  2  byte offset of the load address
mem_resp_valid  in  1  memory response (load data or store ack) valid
mem_resp_data  in  DATA_WIDTH  raw aligned 32-bit word from memory
mem_resp_ready  out  1  unit accepts the memory response
rf_wen  out  1  register-file write enable
rf_waddr  out  ADDR_WIDTH  register-file write index
rf_wdata  out  DATA_WIDTH  register-file write data
commit  out  1  one-cycle retire strobe; drives register-file write gating

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst: sampled on the clk rising edge.
- Reset values: state=IDLE, in_ready=1, mem_resp_ready=0, rf_wen=0, rf_waddr=0, rf_wdata=0, commit=0. All captured fields clear to 0.
- FSM states: IDLE, WAIT_MEM, WRITE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture rd, rd_wen, alu_result, mem_op, is_load, funct3 and addr_low.
  - Next state is WAIT_MEM if in_mem_op, else WRITE.
- WAIT_MEM:
  - in_ready=0, mem_resp_ready=1.
  - On mem_resp_valid, capture mem_resp_data and go to WRITE.
  - Stays in WAIT_MEM indefinitely with no timeout.
- WRITE: lasts exactly one cycle.
  - commit=1.
  - rf_wen = captured rd_wen && rd!=0.
  - rf_waddr = captured rd.
  - rf_wdata = load result if (mem_op && is_load), else alu_result.
  - Next state is IDLE.
- Outputs are registered/decoded from state. rf_wen, rf_waddr and rf_wdata are valid only during the WRITE cycle; outside WRITE, rf_wen=0 and commit=0.
- Latency:
  - Non-memory op accepted at edge N: commit and write during cycle N+1; in_ready returns at N+2.
  - Memory op: commit occurs the cycle after the mem_resp_valid handshake.
- Throughput: at most one instruction per 2 cycles; no back-to-back acceptance.
- Load extension, using byte b = word >> (8*addr_low) and half h = word >> (16*addr_low[1]):
  - LB: sign-extend b[7:0].
  - LBU: zero-extend b[7:0].
  - LH: sign-extend h[15:0].
  - LHU: zero-extend h[15:0].
  - LW: full word.
  - funct3 3/6/7: full word, no trap.
  - LH/LHU ignore addr_low[0]; LW ignores addr_low.
- Stores (mem_op=1, is_load=0): wait for the ack, then commit. rd_wen is expected 0; if set, alu_result is written.
- rd=0: commit still pulses, rf_wen stays 0.
- mem_resp_valid outside WAIT_MEM: ignored, mem_resp_ready=0.
- in_valid while in_ready=0: ignored; the upstream stage holds it.
- Reset mid-operation, any state: return to IDLE next edge. Captured data is discarded, no commit, no write. A pending memory response after reset is ignored.

Decomposition:
- Shared package: state enum encoding (IDLE=0, WAIT_MEM=1, WRITE=2); funct3 load-code constants LB/LH/LW/LBU/LHU.
- Sub-module load_extend: purely combinational (word, addr_low, funct3) -> extended data; reusable by a future LSU bypass path.

Test Plan:
- ALU op, in_rd=5, in_rd_wen=1, in_alu_result=0x1234_5678, accepted at cycle 0 -> cycle 1: commit=1, rf_wen=1, rf_waddr=5, rf_wdata=0x1234_5678; in_ready=1 at cycle 2.
- LB, addr_low=3, resp word 0x80FF_0011 after 4 wait cycles -> commit the cycle after the response, rf_wdata=0xFFFF_FF80. LBU same stimulus -> 0x0000_0080.
- LH, addr_low=2, word 0x8001_7FFF -> 0xFFFF_8001. LHU -> 0x0000_8001. LW, addr_low=1 -> 0x8001_7FFF.
- Store, mem_resp_valid asserted in IDLE first (ignored), then in WAIT_MEM -> single commit pulse, rf_wen=0. Also: ALU op with rd=0 -> commit=1, rf_wen=0.
- Reset asserted in WAIT_MEM, then mem_resp_valid the next cycle -> no commit, rf_wen never 1, in_ready=1 after reset.
- Back-to-back in_valid held high for 3 ALU ops -> accepts on cycles 0, 2, 4; exactly 3 commit pulses with matching rd/data.
